// File: rtl/fp_add_pkg.sv
// Shared widths, constants and stage record types for the FP32 adder back end
// (normalize, round-to-nearest-even, pack).
package fp_add_pkg;

    localparam int MAN_W   = 23;
    localparam int EXP_W   = 8;
    localparam int GRS_W   = 3;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // hidden + mantissa + G/R/S, and the raw adder output with its carry on top
    localparam int NRM_W = MAN_W + 1 + GRS_W;
    localparam int SUM_W = NRM_W + 1;
    localparam int LZ_W  = 5;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
    } fp32_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
        logic zero;
    } flags_t;

    typedef struct packed {
        logic             sign;
        logic             zero;
        logic [EXP_W:0]   e;
        logic [LZ_W-1:0]  shift;
        logic [NRM_W-1:0] m;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic             zero;
        logic [EXP_W:0]   e;
        logic [MAN_W:0]   m;
        logic             round_up;
        logic             inexact;
    } s2_t;

    function automatic fp32_t fp_inf(input logic sign);
        fp32_t r;
        r.sign = sign;
        r.exp  = '1;
        r.mant = '0;
        return r;
    endfunction

endpackage

// File: rtl/fp_add_norm_round_lzc.sv
// Combinational 27-bit leading-zero counter; count is 27 and zero_o is set
// when the input is all zeros.
module fp_lzc27
    import fp_add_pkg::*;
(
    input  logic [NRM_W-1:0] data_i,
    output logic [LZ_W-1:0]  count_o,
    output logic             zero_o
);

    // NOTE: the default is assigned before the loop so every path drives count_o and no latch is inferred.
    always_comb begin
        count_o = LZ_W'(NRM_W);
        for (int i = 0; i < NRM_W; i++) begin
            if (data_i[i]) count_o = LZ_W'(NRM_W - 1 - i);
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/fp_add_norm_round.sv
// FP32 adder back end: 3-stage normalize / round-to-nearest-even / pack pipeline
// with a valid/ready handshake in which all stages advance together.
module fp_add_norm_round
    import fp_add_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] sum,
    input  logic [EXP_W-1:0] exp_in,
    input  logic             sign_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             ovf,
    output logic             unf,
    output logic             inx,
    output logic             zero
);

    logic       adv;
    logic       v1_q, v2_q, v3_q;
    s1_t        s1_d, s1_q;
    s2_t        s2_d, s2_q;
    fp32_t      res_d, res_q;
    flags_t     flg_d, flg_q;

    logic [LZ_W-1:0]  lz;
    logic             lz_zero;
    logic [EXP_W-1:0] e_eff;
    logic [EXP_W-1:0] lim;

    assign adv      = ~v3_q | out_ready;
    assign in_ready = adv;

    fp_lzc27 u_lzc (
        .data_i  (sum[NRM_W-1:0]),
        .count_o (lz),
        .zero_o  (lz_zero)
    );

    // Stage 1: fold the adder carry back in, or pick a left shift that stops at the minimum exponent.
    assign e_eff = (exp_in == '0) ? EXP_W'(1) : exp_in;
    assign lim   = e_eff - EXP_W'(1);

    always_comb begin
        s1_d       = '0;
        s1_d.sign  = sign_in;
        s1_d.zero  = lz_zero & ~sum[SUM_W-1];
        if (sum[SUM_W-1]) begin
            s1_d.m     = {sum[SUM_W-1:2], sum[1] | sum[0]};
            s1_d.e     = {1'b0, e_eff} + (EXP_W+1)'(1);
            s1_d.shift = '0;
        end else begin
            s1_d.m = sum[NRM_W-1:0];
            if ({{(EXP_W-LZ_W){1'b0}}, lz} <= lim) s1_d.shift = lz;
            else                                  s1_d.shift = lim[LZ_W-1:0];
            s1_d.e = {1'b0, e_eff} - {{(EXP_W+1-LZ_W){1'b0}}, s1_d.shift};
        end
    end

    // Stage 2: apply the shift and derive the RNE decision from G/R/S.
    logic [NRM_W-1:0] m_sh;
    logic             g, r, s;

    always_comb begin
        m_sh          = s1_q.m << s1_q.shift;
        g             = m_sh[2];
        r             = m_sh[1];
        s             = m_sh[0];
        s2_d          = '0;
        s2_d.sign     = s1_q.sign;
        s2_d.zero     = s1_q.zero;
        s2_d.e        = s1_q.e;
        s2_d.m        = m_sh[NRM_W-1:GRS_W];
        s2_d.round_up = g & (r | s | m_sh[GRS_W]);
        s2_d.inexact  = g | r | s;
    end

    // Stage 3: increment, then renormalize a carry to 2^24 or a denormal promoted to normal.
    logic [MAN_W+1:0] m25;
    logic [EXP_W:0]   exp_out;

    always_comb begin
        m25     = {1'b0, s2_q.m} + (MAN_W+2)'(s2_q.round_up);
        res_d   = '0;
        flg_d   = '0;
        exp_out = '0;
        if (m25[MAN_W+1]) begin
            exp_out    = s2_q.e + (EXP_W+1)'(1);
            res_d.mant = '0;
        end else begin
            exp_out    = m25[MAN_W] ? s2_q.e : '0;
            res_d.mant = m25[MAN_W-1:0];
        end
        res_d.sign = s2_q.sign;
        res_d.exp  = exp_out[EXP_W-1:0];

        if (s2_q.zero) begin
            res_d      = '0;
            flg_d.zero = 1'b1;
        end else if (exp_out >= (EXP_W+1)'(EXP_MAX)) begin
            res_d     = fp_inf(s2_q.sign);
            flg_d.ovf = 1'b1;
            flg_d.inx = 1'b1;
        end else begin
            flg_d.inx = s2_q.inexact;
            flg_d.unf = (exp_out == '0) & s2_q.inexact;
        end
    end

    // NOTE: non-blocking assignments make every stage capture its neighbour's pre-edge value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
            flg_q <= '0;
        end else if (adv) begin
            v1_q  <= in_valid;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            res_q <= res_d;
            flg_q <= flg_d;
        end
    end

    assign out_valid = v3_q;
    assign result    = res_q;
    assign ovf       = flg_q.ovf;
    assign unf       = flg_q.unf;
    assign inx       = flg_q.inx;
    assign zero      = flg_q.zero;

endmodule
